// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry output FIFO and a saturating
// illegal-instruction counter. Slot 0 is always the head, so head outputs come straight from registers.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    logic [2:0]       w_fmt;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    logic [1:0]       r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_imm0, r_imm1;
    logic [2:0]       r_fmt0, r_fmt1;
    logic             r_ill0, r_ill1;
    logic [CNT_W-1:0] r_cnt;

    // Opcode classification; a non-11 low pair is never a valid 32-bit encoding
    always_comb begin
        w_fmt = FMT_ILL;
        if (instruction[1:0] == 2'b11) begin
            case (instruction[6:0])
                7'b0000011, 7'b0010011, 7'b0011011,
                7'b1100111, 7'b1110011:             w_fmt = FMT_I;
                7'b0100011:                         w_fmt = FMT_S;
                7'b1100011:                         w_fmt = FMT_B;
                7'b0110111, 7'b0010111:             w_fmt = FMT_U;
                7'b1101111:                         w_fmt = FMT_J;
                7'b0110011, 7'b0111011:             w_fmt = FMT_NONE;
                default:                            w_fmt = FMT_ILL;
            endcase
        end
    end

    // Immediates are assembled sign-extended to 32 bits, then widened to XLEN
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: w_imm32 = {instruction[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = r_out_valid && out_ready;
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_imm0      <= '0;
            r_imm1      <= '0;
            r_fmt0      <= FMT_NONE;
            r_fmt1      <= FMT_NONE;
            r_ill0      <= 1'b0;
            r_ill1      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            if (w_push && (w_fmt == FMT_ILL) && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            // Shift-register FIFO: a pop moves slot 1 into slot 0
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_imm0 <= w_imm; r_fmt0 <= w_fmt; r_ill0 <= (w_fmt == FMT_ILL);
                    end else begin
                        r_imm1 <= w_imm; r_fmt1 <= w_fmt; r_ill1 <= (w_fmt == FMT_ILL);
                    end
                end
                2'b01: begin
                    r_imm0 <= r_imm1; r_fmt0 <= r_fmt1; r_ill0 <= r_ill1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_imm0 <= w_imm; r_fmt0 <= w_fmt; r_ill0 <= (w_fmt == FMT_ILL);
                    end else begin
                        r_imm0 <= r_imm1; r_fmt0 <= r_fmt1; r_ill0 <= r_ill1;
                        r_imm1 <= w_imm; r_fmt1 <= w_fmt; r_ill1 <= (w_fmt == FMT_ILL);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign imm_data    = r_imm0;
    assign imm_fmt     = r_fmt0;
    assign illegal     = r_ill0;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;
    logic        in_ready, out_valid, illegal;
    logic [63:0] imm_data;
    logic [2:0]  imm_fmt;
    logic [15:0] illegal_cnt;
    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm_data32;
    logic [2:0]  imm_fmt32;
    logic [15:0] illegal_cnt32;

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_cnt;
    logic        m_started;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .imm_data(imm_data), .imm_fmt(imm_fmt), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_data(imm_data32), .imm_fmt(imm_fmt32), .illegal(illegal32), .illegal_cnt(illegal_cnt32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table and bit-field rules
    function automatic ent_t ref_decode(input logic [31:0] i);
        ent_t   e;
        longint v;
        logic [6:0] op;
        op = i[6:0];
        v  = 0;
        if (i[1:0] != 2'b11) e.fmt = 3'd7;
        else if (op == 7'h03 || op == 7'h13 || op == 7'h1B || op == 7'h67 || op == 7'h73) e.fmt = 3'd1;
        else if (op == 7'h23) e.fmt = 3'd2;
        else if (op == 7'h63) e.fmt = 3'd3;
        else if (op == 7'h37 || op == 7'h17) e.fmt = 3'd4;
        else if (op == 7'h6F) e.fmt = 3'd5;
        else if (op == 7'h33 || op == 7'h3B) e.fmt = 3'd0;
        else e.fmt = 3'd7;
        case (e.fmt)
            3'd1: v = longint'($signed(i[31:20]));
            3'd2: v = longint'($signed({i[31:25], i[11:7]}));
            3'd3: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd4: v = longint'($signed(i[31:12])) * 4096;
            3'd5: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: v = 0;
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(m_started && m_q.size() != 2));
        check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
        if (m_q.size() != 0) begin
            check("imm_data", imm_data, m_q[0].imm);
            check("imm_fmt", 64'(imm_fmt), 64'(m_q[0].fmt));
            check("illegal", 64'(illegal), 64'(m_q[0].fmt == 3'd7));
            check("imm_data32", 64'(imm_data32), 64'(m_q[0].imm[31:0]));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
        logic push, pop;
        ent_t e;
        in_valid    = v;
        instruction = ins;
        out_ready   = ordy;
        push = v && m_started && (m_q.size() != 2);
        pop  = ordy && (m_q.size() != 0);
        @(posedge clk);
        e = ref_decode(ins);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(e);
            if (e.fmt == 3'd7 && m_cnt != 16'hFFFF) m_cnt++;
        end
        m_started = 1'b1;
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt     = '0;
        m_started = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, 32'h0, 1'b1);
    endtask

    logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
        model_reset();
        #1;
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("init_imm", imm_data, 64'd0);
        check("init_fmt", 64'(imm_fmt), 64'd0);
        check("init_illegal", 64'(illegal), 64'd0);
        check("init_cnt", 64'(illegal_cnt), 64'd0);
        #21;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, 32'h0, 1'b1);
        check("rel_in_ready_1", 64'(in_ready), 64'd1);

        // lw x1,-4(x2)
        step(1'b1, 32'hFFC12083, 1'b1);
        check("lw_imm", imm_data, 64'hFFFFFFFFFFFFFFFC);
        check("lw_fmt", 64'(imm_fmt), 64'd1);
        check("lw_ill", 64'(illegal), 64'd0);
        check("lw_valid", 64'(out_valid), 64'd1);
        // beq x0,x0,-8
        step(1'b1, 32'hFE000CE3, 1'b1);
        check("beq_imm", imm_data, 64'hFFFFFFFFFFFFFFF8);
        check("beq_fmt", 64'(imm_fmt), 64'd3);
        // lui x5,0x80000
        step(1'b1, 32'h800002B7, 1'b1);
        check("lui_imm64", imm_data, 64'hFFFFFFFF80000000);
        check("lui_imm32", 64'(imm_data32), 64'h80000000);
        check("lui_fmt", 64'(imm_fmt), 64'd4);
        step(1'b0, 32'h0, 1'b1);

        // Backpressure: I, S, J with consumer stalled
        step(1'b1, 32'h00500093, 1'b0);
        step(1'b1, 32'hFE112E23, 1'b0);
        check("bp_full", 64'(in_ready), 64'd0);
        step(1'b1, 32'h0080006F, 1'b0);
        check("bp_held_fmt", 64'(imm_fmt), 64'd1);
        step(1'b1, 32'h0080006F, 1'b1);
        check("bp_order_s", 64'(imm_fmt), 64'd2);
        step(1'b1, 32'h0080006F, 1'b1);
        check("bp_order_j", 64'(imm_fmt), 64'd5);
        check("bp_j_imm", imm_data, 64'd8);
        step(1'b0, 32'h0, 1'b1);
        check("bp_empty", 64'(out_valid), 64'd0);

        // Illegal all-zero word
        check("ill_cnt0", 64'(illegal_cnt), 64'd0);
        step(1'b1, 32'h00000000, 1'b1);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_fmt", 64'(imm_fmt), 64'd7);
        check("ill_imm", imm_data, 64'd0);
        check("ill_cnt1", 64'(illegal_cnt), 64'd1);
        step(1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom();
            if ($urandom_range(3) != 0) r[6:0] = ops[$urandom_range(13)];
            step(1'($urandom_range(1)), r, 1'($urandom_range(3) != 0));
        end

        // Counter saturation
        do_reset();
        for (int n = 0; n < 65535; n++) step(1'b1, 32'h00000000, 1'b1);
        check("sat_ffff", 64'(illegal_cnt), 64'hFFFF);
        step(1'b1, 32'h00000000, 1'b1);
        check("sat_hold", 64'(illegal_cnt), 64'hFFFF);

        // Asynchronous reset with two entries held
        step(1'b1, 32'h00100093, 1'b0);
        step(1'b1, 32'h00200093, 1'b0);
        check("mid_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_cnt", 64'(illegal_cnt), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFC12083, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
